// File: rtl/conv_request_scheduler.sv
// Request FIFO plus issue/wait/hold sequencer feeding a fixed-latency fixed/float converter.
// Results return in request order with their tags over a valid/ready handshake.
module conv_request_scheduler #(
    parameter int DEPTH        = 4,
    parameter int CONV_LATENCY = 1,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_number,
    input  logic [4:0]       in_fixpointpos,
    input  logic             in_opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      cv_number,
    output logic [4:0]       cv_fixpointpos,
    output logic             cv_opcode,
    input  logic [31:0]      cv_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_opcode,
    output logic             busy,
    output logic [15:0]      conv_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(CONV_LATENCY + 1);
    localparam int ENT_W = 32 + 5 + 1 + TAG_W;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cv_number_q, cv_number_d;
    logic [4:0]       cv_fixpointpos_q, cv_fixpointpos_d;
    logic             cv_opcode_q, cv_opcode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_opcode_q, out_opcode_d;
    logic [15:0]      conv_count_q, conv_count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Acceptance depends only on registered occupancy: a same-cycle pop never frees a slot early.
    assign in_ready = (occ_q != OCC_W'(DEPTH));
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        occ_d            = occ_q;
        state_d          = state_q;
        cnt_d            = cnt_q;
        cv_number_d      = cv_number_q;
        cv_fixpointpos_d = cv_fixpointpos_q;
        cv_opcode_d      = cv_opcode_q;
        tag_d            = tag_q;
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_tag_d        = out_tag_q;
        out_opcode_d     = out_opcode_q;
        conv_count_d     = conv_count_q;
        push             = in_valid && in_ready;
        pop              = 1'b0;

        case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    pop = 1'b1;
                    {cv_number_d, cv_fixpointpos_d, cv_opcode_d, tag_d} = head;
                    cnt_d   = CNT_W'(CONV_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt reaches zero once the converter has had CONV_LATENCY edges with stable inputs.
                if (cnt_q == '0) begin
                    out_result_d = cv_result;
                    out_tag_d    = tag_q;
                    out_opcode_d = cv_opcode_q;
                    out_valid_d  = 1'b1;
                    state_d      = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    conv_count_d = conv_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {in_number, in_fixpointpos, in_opcode, in_tag};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            state_q          <= IDLE;
            cnt_q            <= '0;
            cv_number_q      <= '0;
            cv_fixpointpos_q <= '0;
            cv_opcode_q      <= 1'b0;
            tag_q            <= '0;
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_tag_q        <= '0;
            out_opcode_q     <= 1'b0;
            conv_count_q     <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cv_number_q      <= cv_number_d;
            cv_fixpointpos_q <= cv_fixpointpos_d;
            cv_opcode_q      <= cv_opcode_d;
            tag_q            <= tag_d;
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_tag_q        <= out_tag_d;
            out_opcode_q     <= out_opcode_d;
            conv_count_q     <= conv_count_d;
        end
    end

    assign cv_number      = cv_number_q;
    assign cv_fixpointpos = cv_fixpointpos_q;
    assign cv_opcode      = cv_opcode_q;
    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_tag        = out_tag_q;
    assign out_opcode     = out_opcode_q;
    assign conv_count     = conv_count_q;
    assign busy           = (state_q != IDLE) || (occ_q != '0);
endmodule

// File: tb/tb_conv_request_scheduler.sv
// Bench for conv_request_scheduler: directed scenarios plus a randomized run against a
// transaction-level model; a second instance runs with a three-stage converter.
module tb_conv_request_scheduler;
    localparam int DEPTH = 4;
    localparam int LA    = 1;
    localparam int LB    = 3;
    localparam int TW    = 4;

    typedef struct packed {
        logic [31:0]   num;
        logic [4:0]    fp;
        logic          op;
        logic [TW-1:0] tag;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_cv_opcode, a_out_valid, a_out_ready, a_out_opcode, a_busy;
    logic [31:0]   a_in_number, a_cv_number, a_cv_result, a_out_result;
    logic [4:0]    a_in_fixpointpos, a_cv_fixpointpos;
    logic          a_in_opcode;
    logic [TW-1:0] a_in_tag, a_out_tag;
    logic [15:0]   a_conv_count;

    logic          b_in_valid, b_in_ready, b_cv_opcode, b_out_valid, b_out_ready, b_out_opcode, b_busy;
    logic [31:0]   b_in_number, b_cv_number, b_cv_result, b_out_result;
    logic [4:0]    b_in_fixpointpos, b_cv_fixpointpos;
    logic          b_in_opcode;
    logic [TW-1:0] b_in_tag, b_out_tag;
    logic [15:0]   b_conv_count;
    logic [31:0]   b_stage1, b_stage2;

    int checks = 0;
    int errors = 0;

    conv_request_scheduler #(.DEPTH(DEPTH), .CONV_LATENCY(LA), .TAG_W(TW)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_number(a_in_number), .in_fixpointpos(a_in_fixpointpos), .in_opcode(a_in_opcode),
        .in_tag(a_in_tag), .cv_number(a_cv_number), .cv_fixpointpos(a_cv_fixpointpos),
        .cv_opcode(a_cv_opcode), .cv_result(a_cv_result), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_result(a_out_result), .out_tag(a_out_tag),
        .out_opcode(a_out_opcode), .busy(a_busy), .conv_count(a_conv_count)
    );

    conv_request_scheduler #(.DEPTH(DEPTH), .CONV_LATENCY(LB), .TAG_W(TW)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_number(b_in_number), .in_fixpointpos(b_in_fixpointpos), .in_opcode(b_in_opcode),
        .in_tag(b_in_tag), .cv_number(b_cv_number), .cv_fixpointpos(b_cv_fixpointpos),
        .cv_opcode(b_cv_opcode), .cv_result(b_cv_result), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_result(b_out_result), .out_tag(b_out_tag),
        .out_opcode(b_out_opcode), .busy(b_busy), .conv_count(b_conv_count)
    );

    // Converter stand-in: fix->float for opcode 0, an arbitrary scramble for opcode 1.
    function automatic logic [31:0] conv_ref(logic [31:0] n, logic [4:0] p, logic op);
        int          m;
        logic [31:0] mant;
        logic [7:0]  e;
        if (op) return n ^ 32'h5A5A5A5A ^ {27'd0, p};
        if (n == 32'd0) return 32'd0;
        m = 0;
        for (int i = 0; i < 32; i++) if (n[i]) m = i;
        e = 8'(m - int'(p) + 127);
        if (m <= 23) mant = n << (23 - m);
        else mant = n >> (m - 23);
        return {1'b0, e, mant[22:0]};
    endfunction

    always_ff @(posedge clk) begin
        a_cv_result <= conv_ref(a_cv_number, a_cv_fixpointpos, a_cv_opcode);
        b_stage1    <= conv_ref(b_cv_number, b_cv_fixpointpos, b_cv_opcode);
        b_stage2    <= b_stage1;
        b_cv_result <= b_stage2;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_in_ready"}, a_in_ready, 1);
        chk({pfx, "_out_valid"}, a_out_valid, 0);
        chk({pfx, "_cv_number"}, a_cv_number, 0);
        chk({pfx, "_conv_count"}, a_conv_count, 0);
        chk({pfx, "_busy"}, a_busy, 0);
        chk({pfx, "_out_result"}, a_out_result, 0);
    endtask

    task automatic random_phase(input int ncyc);
        req_t        q[$];
        req_t        cur, r;
        bit          inflight, vld, push;
        int          cap_at;
        logic [15:0] cnt;
        logic [31:0] cv_last;
        inflight = 0; vld = 0; cap_at = 0; cnt = '0; cv_last = '0; cur = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("rnd_in_ready", a_in_ready, q.size() != DEPTH);
            chk("rnd_out_valid", a_out_valid, vld);
            chk("rnd_busy", a_busy, inflight || q.size() != 0);
            chk("rnd_conv_count", a_conv_count, cnt);
            chk("rnd_cv_number", a_cv_number, cv_last);
            if (vld) begin
                chk("rnd_out_result", a_out_result, conv_ref(cur.num, cur.fp, cur.op));
                chk("rnd_out_tag", a_out_tag, cur.tag);
                chk("rnd_out_opcode", a_out_opcode, cur.op);
            end
            a_in_valid       = 1'($urandom_range(0, 1));
            a_in_number      = $urandom;
            a_in_fixpointpos = 5'($urandom);
            a_in_opcode      = 1'($urandom);
            a_in_tag         = TW'($urandom);
            a_out_ready      = ($urandom_range(0, 3) != 0);
            push = a_in_valid && (q.size() != DEPTH);
            // Issue at edge c, capture at edge c+L+1, release on the first ready edge after.
            if (!inflight) begin
                if (q.size() > 0) begin
                    cur      = q.pop_front();
                    cv_last  = cur.num;
                    inflight = 1;
                    cap_at   = c + LA + 1;
                end
            end else if (!vld) begin
                if (c == cap_at) vld = 1;
            end else if (a_out_ready) begin
                vld      = 0;
                inflight = 0;
                cnt++;
            end
            if (push) begin
                r = '{num: a_in_number, fp: a_in_fixpointpos, op: a_in_opcode, tag: a_in_tag};
                q.push_back(r);
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    req_t        f_req [8];
    int          t, got, w;
    logic [31:0] r0, r1;

    initial begin
        a_in_valid = 0; a_in_number = 0; a_in_fixpointpos = 0; a_in_opcode = 0; a_in_tag = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_number = 0; b_in_fixpointpos = 0; b_in_opcode = 0; b_in_tag = 0; b_out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("init");

        // Single request, latency 1
        a_in_valid = 1; a_in_number = 32'h0000_0300; a_in_fixpointpos = 5'd8;
        a_in_opcode = 0; a_in_tag = 4'd3; a_out_ready = 1;
        @(negedge clk);
        a_in_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("single_out_valid", a_out_valid, k == 3);
        end
        chk("single_out_result", a_out_result, 32'h4040_0000);
        chk("single_out_tag", a_out_tag, 3);
        chk("single_out_opcode", a_out_opcode, 0);
        @(negedge clk);
        chk("single_conv_count", a_conv_count, 1);
        chk("single_released", a_out_valid, 0);

        // Fill with consumer stalled
        a_out_ready = 0;
        t = 0;
        for (int c = 0; c < 12; c++) begin
            if (t < 8) begin
                f_req[t] = '{num: $urandom, fp: 5'($urandom), op: 1'($urandom), tag: TW'(t)};
                a_in_valid = 1;
                a_in_number = f_req[t].num; a_in_fixpointpos = f_req[t].fp;
                a_in_opcode = f_req[t].op; a_in_tag = f_req[t].tag;
            end else begin
                a_in_valid = 0;
            end
            w = int'(a_in_ready && a_in_valid);
            @(negedge clk);
            t += w;
        end
        chk("fill_accepted", t, DEPTH + 1);
        chk("fill_in_ready", a_in_ready, 0);

        // Backpressure in HOLD
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_out_tag", a_out_tag, 0);
            chk("bp_out_result", a_out_result, conv_ref(f_req[0].num, f_req[0].fp, f_req[0].op));
            chk("bp_cv_number", a_cv_number, f_req[0].num);
            @(negedge clk);
        end

        // Drain in order
        a_in_valid = 0; a_out_ready = 1; got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (a_out_valid) begin
                chk("drain_tag", a_out_tag, got);
                chk("drain_result", a_out_result, conv_ref(f_req[got].num, f_req[got].fp, f_req[got].op));
                chk("drain_opcode", a_out_opcode, f_req[got].op);
                got++;
            end
            @(negedge clk);
        end
        chk("drain_count", got, 5);
        chk("drain_conv_count", a_conv_count, 6);

        // Randomized run against the model, then a reset mid-stream
        pulse_reset();
        random_phase(600);
        a_in_valid = 1; a_in_number = $urandom; a_out_ready = 0;
        @(negedge clk);
        a_in_valid = 0;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Async reset while waiting with two requests queued
        a_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_number = 32'h1000 + k; a_in_fixpointpos = 5'd4;
            a_in_opcode = 0; a_in_tag = TW'(5 + k);
        end
        @(negedge clk);
        a_in_valid = 0;
        chk("wait_busy", a_busy, 1);
        chk("wait_out_valid", a_out_valid, 0);
        chk("wait_cv_number", a_cv_number, 32'h1000);
        #2 rst = 1'b1;
        #1;
        check_reset_state("asyncrst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("nostale_out_valid", a_out_valid, 0);
            chk("nostale_busy", a_busy, 0);
        end
        a_in_valid = 1; a_in_number = 32'h0000_0A00; a_in_fixpointpos = 5'd8;
        a_in_opcode = 0; a_in_tag = 4'd9;
        @(negedge clk);
        a_in_valid = 0;
        for (w = 0; w < 10 && !a_out_valid; w++) @(negedge clk);
        chk("newreq_timeout", w < 10, 1);
        chk("newreq_tag", a_out_tag, 9);
        chk("newreq_result", a_out_result, conv_ref(32'h0000_0A00, 5'd8, 1'b0));

        // Latency 3 instance: capture at E0+4, issues six cycles apart
        r0 = $urandom; r1 = $urandom;
        @(negedge clk);
        b_out_ready = 1; b_in_valid = 1; b_in_number = r0; b_in_fixpointpos = 5'd3;
        b_in_opcode = 1; b_in_tag = 4'd1;
        @(negedge clk);
        b_in_number = r1; b_in_opcode = 0; b_in_tag = 4'd2;
        @(negedge clk);
        b_in_valid = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            chk("lat3_out_valid", b_out_valid, (k == 5) || (k == 11));
            chk("lat3_cv_number", b_cv_number, (k < 7) ? r0 : r1);
            if (k == 5) begin
                chk("lat3_tag0", b_out_tag, 1);
                chk("lat3_result0", b_out_result, conv_ref(r0, 5'd3, 1'b1));
            end
            if (k == 11) begin
                chk("lat3_tag1", b_out_tag, 2);
                chk("lat3_result1", b_out_result, conv_ref(r1, 5'd3, 1'b0));
            end
        end
        @(negedge clk);
        chk("lat3_conv_count", b_conv_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
